// File: rtl/gf_poly_reducer.sv
// -----------------------------------------------------------------------------
// gf_poly_reducer
//
// Post-multiplier stage for a GF(2^N) / integer multiplier. In reduce mode it
// takes a 2N-bit carry-less product and reduces it modulo POLY one bit
// position per clock, highest bit first, always spending exactly N cycles so
// the latency does not depend on the data. In bypass mode the integer product
// is passed straight through. One item is in flight at a time.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream product is valid
//   in_ready   block can accept a product (IDLE only)
//   gf_option  1 = reduce modulo POLY, 0 = bypass integer product
//   prod       2N-bit product from the multiplier stage
//   out_valid  out holds a completed result (DONE only)
//   out_ready  downstream accepts out
//   out        result; remainder register, upper N bits zero in reduce mode
//   busy       high while reduction steps are running
// -----------------------------------------------------------------------------
module gf_poly_reducer #(
  parameter int                  DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH:0] POLY       = 5'b10011
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      gf_option,
  input  logic [2*DATA_WIDTH-1:0]   prod,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out,
  output logic                      busy
);

  localparam int N  = DATA_WIDTH;
  localparam int PW = 2 * N;
  localparam int IW = (PW > 1) ? $clog2(PW) : 1;
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  // A reduction polynomial without its leading term would make the
  // bit-by-bit reduction below meaningless, so refuse to build.
  generate
    if (POLY[N] != 1'b1) begin : g_poly_check
      $error("gf_poly_reducer: POLY must have its degree-N bit set");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   rem_reg;
  logic [IW-1:0]   idx_reg;
  logic            mode_reg;

  // POLY aligned so that its leading term sits on each bit position N..2N-1.
  logic [PW-1:0]   poly_shift [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_poly_shift
      assign poly_shift[gi] = PW'(POLY) << gi;
    end
  endgenerate

  logic [OW-1:0]   shift_sel;
  logic            do_xor;
  logic            last_step;
  logic [PW-1:0]   rem_step;

  always_comb begin
    shift_sel = OW'(idx_reg - IW'(N));
    // Only a reduce-mode item ever reaches REDUCE; the mode flag keeps a
    // bypass value from being altered should that ever not hold.
    do_xor    = mode_reg && rem_reg[idx_reg];
    last_step = (idx_reg == IW'(N));
    rem_step  = do_xor ? (rem_reg ^ poly_shift[shift_sel]) : rem_reg;
  end

  // Single state machine; in_ready/out_valid/busy are registered alongside
  // the state so they always agree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      idx_reg   <= IW'(PW - 1);
      mode_reg  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            rem_reg  <= prod;
            mode_reg <= gf_option;
            idx_reg  <= IW'(PW - 1);
            in_ready <= 1'b0;
            if (gf_option) begin
              state_reg <= REDUCE;
              busy      <= 1'b1;
            end else begin
              state_reg <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        REDUCE: begin
          rem_reg <= rem_step;
          if (last_step) begin
            // No early exit: the i=N step always runs, even when the
            // upper bits are already clear.
            state_reg <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            idx_reg   <= IW'(PW - 1);
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out = rem_reg;

endmodule

// File: tb/tb_gf_poly_reducer.sv
// -----------------------------------------------------------------------------
// tb_gf_poly_reducer
//
// Bench for gf_poly_reducer with N=4, POLY=x^4+x+1. Expected results are
// pushed to a scoreboard queue as each product is driven and popped when the
// DUT presents a result. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_gf_poly_reducer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       gf_option;
  logic [7:0] prod;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  gf_poly_reducer #(
    .DATA_WIDTH(4),
    .POLY(5'b10011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .gf_option(gf_option),
    .prod(prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .busy(busy)
  );

  // Carry-less product of two 4-bit values.
  function automatic logic [7:0] clmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++)
      if (b[i]) r = r ^ (8'(a) << i);
    return r;
  endfunction

  // GF(16) product by shift-and-add with reduction after every doubling.
  function automatic logic [7:0] gfmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] x, y, p;
    logic       hi;
    x = a; y = b; p = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[3];
      x  = x << 1;
      if (hi) x = x ^ 4'b0011;
      y  = y >> 1;
    end
    return {4'h0, p};
  endfunction

  // Drive one handshake (caller has ensured in_ready), record the expectation.
  task automatic send(input logic gf, input logic [7:0] p, input logic [7:0] e);
    in_valid  = 1'b1;
    gf_option = gf;
    prod      = p;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid  = 1'b0;
    gf_option = 1'($urandom_range(0, 1));
    prod      = 8'($urandom);
  endtask

  // Wait (bounded) for out_valid; lat counts cycles since the handshake cycle.
  task automatic wait_out(input int bound, input bit rand_rdy,
                          output int lat, output int busy_cnt, output bit seen);
    lat      = 1;
    busy_cnt = 0;
    while (!out_valid && lat < bound) begin
      busy_cnt += int'(busy);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    seen = out_valid;
  endtask

  task automatic resync();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; gf_option = 1'b1; prod = 8'hFF; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_async_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_async_out_valid: got %b expected 0", out_valid); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_in_ready: got %b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_reduce_basic();
    int lat, bc; bit seen; logic [7:0] e;
    out_ready = 1'b1;
    send(1'b1, 8'h78, 8'h01);
    wait_out(20, 1'b0, lat, bc, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL reduce_78_timeout: got no out_valid expected one"); resync(); return; end
    e = exp_q.pop_front();
    checks++; if (out !== e) begin errors++; $display("FAIL reduce_78_out: got %h expected %h", out, e); end
    checks++; if (lat != 5) begin errors++; $display("FAIL reduce_78_latency: got %0d expected 5", lat); end
    checks++; if (bc != 4) begin errors++; $display("FAIL reduce_78_busy_cycles: got %0d expected 4", bc); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reduce_78_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready); end
    $display("reduce prod=78 out=%h lat=%0d", out, lat);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ps [2];
    logic [7:0] es [2];
    int lat, bc; bit seen; logic [7:0] e;
    ps[0] = 8'h2D; es[0] = 8'h0B;
    ps[1] = 8'h4B; es[1] = 8'h07;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", k, in_ready); end
      send(1'b1, ps[k], es[k]);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready_%0d: got %b expected 0", k, in_ready); end
      wait_out(20, 1'b0, lat, bc, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b_timeout_%0d: got no out_valid expected one", k); resync(); return; end
      e = exp_q.pop_front();
      checks++; if (out !== e) begin errors++; $display("FAIL b2b_out_%0d: got %h expected %h", k, out, e); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready_%0d: got %b expected 0", k, in_ready); end
      $display("b2b prod=%h out=%h", ps[k], out);
      @(negedge clk);
    end
  endtask

  task automatic test_bypass();
    int lat, bc; bit seen; logic [7:0] e;
    out_ready = 1'b1;
    send(1'b0, 8'hC3, 8'hC3);
    wait_out(20, 1'b0, lat, bc, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL bypass_timeout: got no out_valid expected one"); resync(); return; end
    e = exp_q.pop_front();
    checks++; if (out !== e) begin errors++; $display("FAIL bypass_out: got %h expected %h", out, e); end
    checks++; if (lat != 1) begin errors++; $display("FAIL bypass_latency: got %0d expected 1", lat); end
    checks++; if (bc != 0) begin errors++; $display("FAIL bypass_busy: got %0d expected 0", bc); end
    $display("bypass prod=C3 out=%h lat=%0d", out, lat);
    @(negedge clk);
  endtask

  task automatic test_stall();
    int lat, bc; bit seen; logic [7:0] e;
    out_ready = 1'b0;
    send(1'b1, 8'h78, 8'h01);
    wait_out(20, 1'b0, lat, bc, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_timeout: got no out_valid expected one"); resync(); return; end
    e = exp_q.pop_front();
    in_valid = 1'b1; gf_option = 1'b0; prod = 8'hAA;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out !== e || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got ov=%b out=%h ir=%b expected ov=1 out=%h ir=0", c, out_valid, out, in_ready, e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== e) begin
      errors++;
      $display("FAIL stall_release: got ov=%b ir=%b out=%h expected ov=0 ir=1 out=%h", out_valid, in_ready, out, e);
    end
    $display("stall prod=78 out=%h held 6 cycles", out);
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit seen; logic [7:0] e;
    out_ready = 1'b1;
    send(1'b1, 8'h78, 8'h01);
    @(negedge clk);                 // second REDUCE cycle
    rst = 1'b1;
    void'(exp_q.pop_back());        // abandoned item produces no output
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h00) begin
      errors++;
      $display("FAIL midreset_state: got busy=%b ov=%b ir=%b out=%h expected 0 0 1 00", busy, out_valid, in_ready, out);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
    send(1'b1, 8'h0F, 8'h0F);
    wait_out(20, 1'b0, lat, bc, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL midreset_timeout: got no out_valid expected one"); resync(); return; end
    e = exp_q.pop_front();
    checks++; if (out !== e) begin errors++; $display("FAIL midreset_out: got %h expected %h", out, e); end
    checks++; if (lat != 5) begin errors++; $display("FAIL midreset_latency: got %0d expected 5", lat); end
    $display("midreset fresh prod=0F out=%h lat=%0d", out, lat);
    @(negedge clk);
    // Reset in DONE drops the pending result.
    out_ready = 1'b0;
    send(1'b0, 8'h55, 8'h55);
    void'(exp_q.pop_back());
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL donereset_out_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL donereset_idle: got ov=%b ir=%b expected 0 1", out_valid, in_ready); end
    $display("donereset checked");
  endtask

  task automatic test_boundary();
    logic       gfs  [5];
    logic [7:0] ps   [5];
    logic [7:0] es   [5];
    int         lats [5];
    int lat, bc; bit seen; logic [7:0] e;
    gfs[0] = 1'b1; ps[0] = 8'h00; es[0] = 8'h00; lats[0] = 5;
    gfs[1] = 1'b0; ps[1] = 8'h00; es[1] = 8'h00; lats[1] = 1;
    gfs[2] = 1'b1; ps[2] = 8'h09; es[2] = 8'h09; lats[2] = 5;
    gfs[3] = 1'b0; ps[3] = 8'hFF; es[3] = 8'hFF; lats[3] = 1;
    gfs[4] = 1'b1; ps[4] = 8'h55; es[4] = 8'h0A; lats[4] = 5;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(gfs[k], ps[k], es[k]);
      wait_out(20, 1'b0, lat, bc, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL boundary_timeout_%0d: got no out_valid expected one", k); resync(); continue; end
      e = exp_q.pop_front();
      checks++; if (out !== e) begin errors++; $display("FAIL boundary_out_%0d: got %h expected %h", k, out, e); end
      checks++; if (lat != lats[k]) begin errors++; $display("FAIL boundary_latency_%0d: got %0d expected %0d", k, lat, lats[k]); end
      $display("boundary gf=%b prod=%h out=%h lat=%0d", gfs[k], ps[k], out, lat);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [3:0] a, b; logic g; logic [7:0] p, ev, e;
    int lat, bc, stalls, bad; bit seen;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      a = 4'($urandom); b = 4'($urandom); g = 1'($urandom_range(0, 1));
      if (g) begin p = clmul(a, b); ev = gfmul(a, b); end
      else   begin p = 8'(a) * 8'(b); ev = p; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; bad++; $display("FAIL rand_ready_%0d: got %b expected 1", n, in_ready); resync(); continue; end
      send(g, p, ev);
      wait_out(20, 1'b1, lat, bc, seen);
      checks++;
      if (!seen) begin errors++; bad++; $display("FAIL rand_timeout_%0d: got no out_valid expected one", n); resync(); continue; end
      out_ready = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (out !== e || lat != (g ? 5 : 1)) begin
        errors++; bad++;
        $display("FAIL rand_out_%0d: got out=%h lat=%0d expected out=%h lat=%0d (gf=%b a=%h b=%h)", n, out, lat, e, (g ? 5 : 1), g, a, b);
      end
      stalls = $urandom_range(0, 3);
      for (int s = 0; s < stalls; s++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== e) begin errors++; bad++; $display("FAIL rand_stall_%0d: got ov=%b out=%h expected ov=1 out=%h", n, out_valid, out, e); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; bad++; $display("FAIL rand_release_%0d: got ov=%b ir=%b expected 0 1", n, out_valid, in_ready); end
      $display("rand %0d gf=%b a=%h b=%h out=%h exp=%h stalls=%0d", n, g, a, b, out, e, stalls);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_queue_left: got %0d expected 0", exp_q.size()); end
    $display("test_random done, %0d bad items", bad);
  endtask

  initial begin
    test_reset();
    test_reduce_basic();
    test_back_to_back();
    test_bypass();
    test_stall();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gf_poly_reducer.md
GF_POLY_REDUCER -- requirements
Module: gf_poly_reducer

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set field degree N; operand width N, product width 2N.
REQ-002 Parameter POLY, default 5'b10011 (x^4+x+1), width N+1, SHALL be the irreducible reduction polynomial; bit N SHALL be 1, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 in_valid  input  1  SHALL mean the upstream multiplier product is valid.
REQ-006 in_ready  output  1  SHALL mean the block can accept a product.
REQ-007 gf_option  input  1  SHALL select the mode: 1 = reduce mod POLY, 0 = bypass the integer product.
REQ-008 prod  input  2N  SHALL be the product from the multiplier stage: carry-less when gf_option=1, integer when gf_option=0.
REQ-009 out_valid  output  1  SHALL mean out holds a completed result.
REQ-010 out_ready  input  1  SHALL mean the downstream stage accepts out.
REQ-011 out  output  2N  SHALL be the result; in reduce mode bits [2N-1:N] SHALL be 0.
REQ-012 busy  output  1  SHALL be high in the REDUCE state only.

Function
REQ-013 FSM states SHALL be IDLE, REDUCE and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 Accept = in_valid&&in_ready at an edge; prod and gf_option SHALL be captured into a 2N-bit remainder register and a mode flag; inputs SHALL be ignored outside IDLE.
REQ-015 On accept with gf_option=0: IDLE->DONE, out=prod unchanged; latency 1 cycle from the handshake cycle to out_valid.
REQ-016 On accept with gf_option=1: IDLE->REDUCE with bit index i=2N-1.
REQ-017 Each REDUCE cycle: if rem[i]=1 then rem ^= POLY<<(i-N); i decrements; after the i=N step (exactly N REDUCE cycles), REDUCE->DONE.
REQ-018 Reduce-mode latency SHALL be N+1 cycles from the handshake cycle to out_valid; it SHALL NOT depend on data (no early exit).
REQ-019 DONE: out and out_valid SHALL be held stable until out_ready=1; on out_valid&&out_ready, DONE->IDLE.
REQ-020 Throughput: there is no accept in the DONE cycle; the earliest next accept is the cycle after the output handshake.
REQ-021 Boundary: prod=0 SHALL yield 0; prod<2^N in reduce mode SHALL pass unchanged after the full N cycles; out_ready asserted early (before DONE) SHALL have no effect.
REQ-022 out SHALL present the remainder register in all states; its value is defined only while out_valid=1.

Reset
REQ-023 While rst=1: state=IDLE, remainder=0, index=2N-1, mode=0; outputs in_ready=1, out_valid=0, busy=0, out=0.
REQ-024 Reset asserted mid-REDUCE or in DONE SHALL abandon the operation with no output handshake; the first accept SHALL be possible on the first edge after rst deasserts.

Verification (N=4, POLY=10011)
REQ-025 gf_option=1, prod=0x78 (12*10 carry-less), out_ready=1 -> out_valid high in the 5th cycle after the handshake, out=0x01, busy high for 4 cycles.
REQ-026 gf_option=1, prod=0x2D (5*9), then prod=0x4B (15*13) back-to-back -> out=0x0B then out=0x07, with in_ready low between the two handshakes.
REQ-027 gf_option=0, prod=0xC3 (15*13 integer) -> out=0xC3 with out_valid the cycle after the handshake.
REQ-028 gf_option=1, prod=0x78, out_ready held 0 for 6 cycles -> out=0x01 and out_valid stay stable, in_ready=0 and new in_valid ignored; release out_ready -> IDLE next cycle.
REQ-029 rst pulsed during the 2nd REDUCE cycle -> out_valid never rises for that item; a fresh prod=0x0F after reset -> out=0x0F.
REQ-030 Randomized: 1000 random a,b with the golden model clmul-then-mod-POLY (gf) or a*b (bypass) and random out_ready stalls -> all results match, no lost or duplicated transfers.
